// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB->ID bypass and flush handling.
// Optional macro STALL_COUNTER_EN adds a 32-bit stall_count output counting stalled cycles.

`ifndef REGSRC_DMEM
`define REGSRC_DMEM 2'd1
`endif

module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ID_valid,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_useRs,
   input  logic        ID_useRt,
   input  logic        ID_RegWrite,
   input  logic [1:0]  ID_RegSrc,
   input  logic [4:0]  ID_WriteReg,
   input  logic        ID_MemWrite,
   input  logic [4:0]  ID_ALUOp,
   input  logic [31:0] ID_rfOut1,
   input  logic [31:0] ID_rfOut2,
   input  logic [31:0] ID_imm32,
   input  logic [31:0] ID_PC,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_WriteReg,
   input  logic [31:0] WB_rfWriteData,
   input  logic        flush,
   output logic        EX_valid,
   output logic [4:0]  EX_rs,
   output logic [4:0]  EX_rt,
   output logic        EX_RegWrite,
   output logic [1:0]  EX_RegSrc,
   output logic [4:0]  EX_WriteReg,
   output logic        EX_MemWrite,
   output logic [4:0]  EX_ALUOp,
   output logic [31:0] EX_rfOut1,
   output logic [31:0] EX_rfOut2,
   output logic [31:0] EX_imm32,
   output logic [31:0] EX_PC,
   output logic        stall
`ifdef STALL_COUNTER_EN
   ,
   output logic [31:0] stall_count
`endif
);

   logic        r_ex_valid;
   logic [4:0]  r_ex_rs;
   logic [4:0]  r_ex_rt;
   logic        r_ex_regwrite;
   logic [1:0]  r_ex_regsrc;
   logic [4:0]  r_ex_writereg;
   logic        r_ex_memwrite;
   logic [4:0]  r_ex_aluop;
   logic [31:0] r_ex_rfout1;
   logic [31:0] r_ex_rfout2;
   logic [31:0] r_ex_imm32;
   logic [31:0] r_ex_pc;

   logic        w_ex_is_load;
   logic        w_rs_hazard;
   logic        w_rt_hazard;
   logic        w_stall;
   logic        w_bubble;
   logic        w_fwd1;
   logic        w_fwd2;
   logic [31:0] w_op1;
   logic [31:0] w_op2;

   // Only a load still in EX can create a hazard; older loads are covered by EX forwarding.
   assign w_ex_is_load = r_ex_valid & r_ex_regwrite & (r_ex_regsrc == `REGSRC_DMEM)
                         & (r_ex_writereg != 5'd0);
   assign w_rs_hazard  = ID_useRs & (r_ex_writereg == ID_rs);
   assign w_rt_hazard  = ID_useRt & (r_ex_writereg == ID_rt);
   assign w_stall      = w_ex_is_load & ID_valid & ~flush & (w_rs_hazard | w_rt_hazard);
   assign w_bubble     = flush | w_stall | ~ID_valid;

   // Register file is written in the same cycle it is read, so bypass the WB value here.
   assign w_fwd1 = WB_RegWrite & (WB_WriteReg != 5'd0) & (WB_WriteReg == ID_rs);
   assign w_fwd2 = WB_RegWrite & (WB_WriteReg != 5'd0) & (WB_WriteReg == ID_rt);
   assign w_op1  = w_fwd1 ? WB_rfWriteData : ID_rfOut1;
   assign w_op2  = w_fwd2 ? WB_rfWriteData : ID_rfOut2;

   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_ex_valid    <= 1'b0;
         r_ex_rs       <= 5'd0;
         r_ex_rt       <= 5'd0;
         r_ex_regwrite <= 1'b0;
         r_ex_regsrc   <= 2'd0;
         r_ex_writereg <= 5'd0;
         r_ex_memwrite <= 1'b0;
         r_ex_aluop    <= 5'd0;
         r_ex_rfout1   <= 32'd0;
         r_ex_rfout2   <= 32'd0;
         r_ex_imm32    <= 32'd0;
         r_ex_pc       <= 32'd0;
      end else begin
         r_ex_valid    <= 1'b1;
         r_ex_rs       <= ID_rs;
         r_ex_rt       <= ID_rt;
         r_ex_regwrite <= ID_RegWrite;
         r_ex_regsrc   <= ID_RegSrc;
         r_ex_writereg <= ID_WriteReg;
         r_ex_memwrite <= ID_MemWrite;
         r_ex_aluop    <= ID_ALUOp;
         r_ex_rfout1   <= w_op1;
         r_ex_rfout2   <= w_op2;
         r_ex_imm32    <= ID_imm32;
         r_ex_pc       <= ID_PC;
      end
   end

`ifdef STALL_COUNTER_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= 32'd0;
      end else if (w_stall) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
`endif

   assign stall       = w_stall;
   assign EX_valid    = r_ex_valid;
   assign EX_rs       = r_ex_rs;
   assign EX_rt       = r_ex_rt;
   assign EX_RegWrite = r_ex_regwrite;
   assign EX_RegSrc   = r_ex_regsrc;
   assign EX_WriteReg = r_ex_writereg;
   assign EX_MemWrite = r_ex_memwrite;
   assign EX_ALUOp    = r_ex_aluop;
   assign EX_rfOut1   = r_ex_rfout1;
   assign EX_rfOut2   = r_ex_rfout2;
   assign EX_imm32    = r_ex_imm32;
   assign EX_PC       = r_ex_pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: hazard stall, bubbles, WB bypass, flush, reset.
// Counter checks are compiled only when STALL_COUNTER_EN is defined.

`timescale 1ns/1ps

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ID_valid;
   logic [4:0]  ID_rs, ID_rt;
   logic        ID_useRs, ID_useRt;
   logic        ID_RegWrite;
   logic [1:0]  ID_RegSrc;
   logic [4:0]  ID_WriteReg;
   logic        ID_MemWrite;
   logic [4:0]  ID_ALUOp;
   logic [31:0] ID_rfOut1, ID_rfOut2, ID_imm32, ID_PC;
   logic        WB_RegWrite;
   logic [4:0]  WB_WriteReg;
   logic [31:0] WB_rfWriteData;
   logic        flush;
   logic        EX_valid;
   logic [4:0]  EX_rs, EX_rt;
   logic        EX_RegWrite;
   logic [1:0]  EX_RegSrc;
   logic [4:0]  EX_WriteReg;
   logic        EX_MemWrite;
   logic [4:0]  EX_ALUOp;
   logic [31:0] EX_rfOut1, EX_rfOut2, EX_imm32, EX_PC;
   logic        stall;
`ifdef STALL_COUNTER_EN
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] RS_ALU  = 2'd0;
   localparam logic [1:0] RS_DMEM = 2'd1;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_useRs(ID_useRs), .ID_useRt(ID_useRt),
      .ID_RegWrite(ID_RegWrite), .ID_RegSrc(ID_RegSrc), .ID_WriteReg(ID_WriteReg),
      .ID_MemWrite(ID_MemWrite), .ID_ALUOp(ID_ALUOp),
      .ID_rfOut1(ID_rfOut1), .ID_rfOut2(ID_rfOut2), .ID_imm32(ID_imm32), .ID_PC(ID_PC),
      .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_rfWriteData(WB_rfWriteData),
      .flush(flush),
      .EX_valid(EX_valid), .EX_rs(EX_rs), .EX_rt(EX_rt),
      .EX_RegWrite(EX_RegWrite), .EX_RegSrc(EX_RegSrc), .EX_WriteReg(EX_WriteReg),
      .EX_MemWrite(EX_MemWrite), .EX_ALUOp(EX_ALUOp),
      .EX_rfOut1(EX_rfOut1), .EX_rfOut2(EX_rfOut2), .EX_imm32(EX_imm32), .EX_PC(EX_PC),
      .stall(stall)
`ifdef STALL_COUNTER_EN
      , .stall_count(stall_count)
`endif
   );

   // Stimulus helpers: drive an ID instruction, advance one edge and settle.
   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic rw,
                           input logic [1:0] src, input logic [4:0] wr, input logic mw,
                           input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [31:0] pc);
      ID_valid = v;  ID_rs = rs;  ID_rt = rt;  ID_useRs = urs;  ID_useRt = urt;
      ID_RegWrite = rw;  ID_RegSrc = src;  ID_WriteReg = wr;  ID_MemWrite = mw;
      ID_ALUOp = op;  ID_rfOut1 = r1;  ID_rfOut2 = r2;  ID_imm32 = imm;  ID_PC = pc;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // lw $8, 4($2)
   task automatic drive_lw8();
      drive_id(1'b1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, RS_DMEM, 5'd8, 1'b0, 5'd3,
               32'h100, 32'h0, 32'h4, 32'h40);
   endtask

   // add $10, $8, $9
   task automatic drive_add(input logic urs);
      drive_id(1'b1, 5'd8, 5'd9, urs, 1'b0, 1'b1, RS_ALU, 5'd10, 1'b0, 5'd1,
               32'h7, 32'h9, 32'h0, 32'h44);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_add(1'b1);
      step();
      rst = 1'b0;
      drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RS_ALU, 5'd0, 1'b0, 5'd0, 0, 0, 0, 0);
      n_checks++;
      if (EX_valid !== 1'b0 || EX_rfOut1 !== 32'h0 || EX_PC !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_regs: valid=%b rfOut1=%h PC=%h, required 0/0/0", EX_valid, EX_rfOut1, EX_PC);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: stall=%b, required 0", stall);
      end
`ifdef STALL_COUNTER_EN
      n_checks++;
      if (stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: stall_count=%0d, required 0", stall_count);
      end
`endif
      $display("txn reset done");
   endtask

   task automatic test_load_use();
      drive_lw8();
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_WriteReg !== 5'd8 || EX_RegSrc !== RS_DMEM || EX_imm32 !== 32'h4 || EX_PC !== 32'h40) begin
         n_fail++;
         $display("FAIL lw_load: valid=%b wr=%0d src=%0d imm=%h pc=%h, required 1/8/1/4/40",
                  EX_valid, EX_WriteReg, EX_RegSrc, EX_imm32, EX_PC);
      end
      drive_add(1'b1);
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_stall: stall=%b, required 1", stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b0 || EX_RegWrite !== 1'b0 || EX_WriteReg !== 5'd0 || EX_ALUOp !== 5'd0) begin
         n_fail++;
         $display("FAIL load_use_bubble: valid=%b rw=%b wr=%0d op=%0d, required 0/0/0/0",
                  EX_valid, EX_RegWrite, EX_WriteReg, EX_ALUOp);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: stall=%b, required 0", stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_WriteReg !== 5'd10 || EX_rs !== 5'd8 || EX_rfOut1 !== 32'h7 || EX_PC !== 32'h44) begin
         n_fail++;
         $display("FAIL held_add_load: valid=%b wr=%0d rs=%0d rf1=%h pc=%h, required 1/10/8/7/44",
                  EX_valid, EX_WriteReg, EX_rs, EX_rfOut1, EX_PC);
      end
`ifdef STALL_COUNTER_EN
      n_checks++;
      if (stall_count !== 32'd1) begin
         n_fail++;
         $display("FAIL load_use_count: stall_count=%0d, required 1", stall_count);
      end
`endif
      $display("txn load-use lw $8 / add $10,$8 done");
   endtask

   task automatic test_no_stall();
      // Load to $0 in EX: matching rs=0 must not stall.
      drive_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, RS_DMEM, 5'd0, 1'b0, 5'd3, 0, 0, 32'h4, 32'h50);
      step();
      drive_id(1'b1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, RS_ALU, 5'd10, 1'b0, 5'd1, 0, 32'h9, 0, 32'h54);
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL no_stall_r0: stall=%b, required 0", stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_PC !== 32'h54) begin
         n_fail++;
         $display("FAIL no_stall_r0_load: valid=%b pc=%h, required 1/54", EX_valid, EX_PC);
      end
      // Real load to $8, but the consumer does not read rs.
      drive_lw8();
      step();
      drive_add(1'b0);
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL no_stall_userS0: stall=%b, required 0", stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_WriteReg !== 5'd10 || EX_PC !== 32'h44) begin
         n_fail++;
         $display("FAIL no_stall_userS0_load: valid=%b wr=%0d pc=%h, required 1/10/44", EX_valid, EX_WriteReg, EX_PC);
      end
      $display("txn no-stall cases done");
   endtask

   task automatic test_forward();
      WB_RegWrite = 1'b1;  WB_WriteReg = 5'd5;  WB_rfWriteData = 32'hAB;
      drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, RS_ALU, 5'd11, 1'b1, 5'd2,
               32'h11, 32'h22, 32'h8, 32'h60);
      step();
      n_checks++;
      if (EX_rfOut1 !== 32'hAB || EX_rfOut2 !== 32'hAB || EX_MemWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL fwd_hit: rf1=%h rf2=%h mw=%b, required ab/ab/1", EX_rfOut1, EX_rfOut2, EX_MemWrite);
      end
      WB_WriteReg = 5'd0;
      #1;
      step();
      n_checks++;
      if (EX_rfOut1 !== 32'h11 || EX_rfOut2 !== 32'h22) begin
         n_fail++;
         $display("FAIL fwd_wb_r0: rf1=%h rf2=%h, required 11/22", EX_rfOut1, EX_rfOut2);
      end
      // Register 0 read with a WB write to $0: value stays the ID one.
      drive_id(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, RS_ALU, 5'd11, 1'b0, 5'd2,
               32'h33, 32'h44, 32'h0, 32'h64);
      step();
      n_checks++;
      if (EX_rfOut1 !== 32'h33 || EX_rfOut2 !== 32'h44) begin
         n_fail++;
         $display("FAIL fwd_rs0: rf1=%h rf2=%h, required 33/44", EX_rfOut1, EX_rfOut2);
      end
      WB_WriteReg = 5'd6;  WB_rfWriteData = 32'hCD;
      #1;
      step();
      n_checks++;
      if (EX_rfOut1 !== 32'h33 || EX_rfOut2 !== 32'hCD) begin
         n_fail++;
         $display("FAIL fwd_rt_only: rf1=%h rf2=%h, required 33/cd", EX_rfOut1, EX_rfOut2);
      end
      WB_RegWrite = 1'b0;
      #1;
      step();
      n_checks++;
      if (EX_rfOut2 !== 32'h44) begin
         n_fail++;
         $display("FAIL fwd_wb_off: rf2=%h, required 44", EX_rfOut2);
      end
      WB_WriteReg = 5'd0;  WB_rfWriteData = 32'h0;
      $display("txn WB bypass cases done");
   endtask

   task automatic test_flush();
      drive_lw8();
      step();
      flush = 1'b1;
      drive_add(1'b1);
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stall: stall=%b, required 0", stall);
      end
      step();
      flush = 1'b0;
      n_checks++;
      if (EX_valid !== 1'b0 || EX_RegWrite !== 1'b0 || EX_PC !== 32'h0) begin
         n_fail++;
         $display("FAIL flush_bubble: valid=%b rw=%b pc=%h, required 0/0/0", EX_valid, EX_RegWrite, EX_PC);
      end
      // Invalid ID instruction also enters as a bubble.
      drive_id(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, RS_DMEM, 5'd12, 1'b1, 5'd7, 1, 2, 3, 32'h70);
      step();
      n_checks++;
      if (EX_valid !== 1'b0 || EX_MemWrite !== 1'b0 || EX_ALUOp !== 5'd0 || EX_imm32 !== 32'h0) begin
         n_fail++;
         $display("FAIL invalid_bubble: valid=%b mw=%b op=%0d imm=%h, required 0/0/0/0",
                  EX_valid, EX_MemWrite, EX_ALUOp, EX_imm32);
      end
      $display("txn flush and invalid-ID bubble done");
   endtask

   task automatic test_back_to_back();
      drive_lw8();
      step();
      // lw $9, 0($8) depends on the lw $8 in EX.
      drive_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, RS_DMEM, 5'd9, 1'b0, 5'd3, 32'h7, 0, 0, 32'h80);
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_stall1: stall=%b, required 1", stall);
      end
      step();
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_WriteReg !== 5'd9 || EX_PC !== 32'h80) begin
         n_fail++;
         $display("FAIL b2b_lw9_load: valid=%b wr=%0d pc=%h, required 1/9/80", EX_valid, EX_WriteReg, EX_PC);
      end
      // add $10, $1, $9 via rt.
      drive_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, RS_ALU, 5'd10, 1'b0, 5'd1, 0, 0, 0, 32'h84);
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_stall_rt: stall=%b, required 1", stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_bubble: valid=%b stall=%b, required 0/0", EX_valid, stall);
      end
      step();
      n_checks++;
      if (EX_valid !== 1'b1 || EX_PC !== 32'h84) begin
         n_fail++;
         $display("FAIL b2b_add_load: valid=%b pc=%h, required 1/84", EX_valid, EX_PC);
      end
`ifdef STALL_COUNTER_EN
      n_checks++;
      if (stall_count !== 32'd3) begin
         n_fail++;
         $display("FAIL b2b_count: stall_count=%0d, required 3", stall_count);
      end
`endif
      $display("txn back-to-back load-use done");
   endtask

   task automatic test_reset_mid();
      drive_lw8();
      step();
      drive_add(1'b1);
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_precond: stall=%b, required 1", stall);
      end
      flush = 1'b1;
      rst   = 1'b1;
      #1;
      step();
      rst   = 1'b0;
      flush = 1'b0;
      #1;
      n_checks++;
      if (EX_valid !== 1'b0 || EX_RegWrite !== 1'b0 || EX_RegSrc !== 2'd0 || EX_WriteReg !== 5'd0 ||
          EX_rs !== 5'd0 || EX_rfOut1 !== 32'h0 || EX_PC !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_regs: valid=%b rw=%b src=%0d wr=%0d rs=%0d rf1=%h pc=%h, required all 0",
                  EX_valid, EX_RegWrite, EX_RegSrc, EX_WriteReg, EX_rs, EX_rfOut1, EX_PC);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_stall: stall=%b, required 0", stall);
      end
`ifdef STALL_COUNTER_EN
      n_checks++;
      if (stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_count: stall_count=%0d, required 0", stall_count);
      end
`endif
      $display("txn mid-stream reset done");
   endtask

`ifdef STALL_COUNTER_EN
   task automatic test_wrap();
      force dut.r_stall_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_count;
      drive_lw8();
      step();
      drive_add(1'b1);
      step();
      n_checks++;
      if (stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL count_wrap: stall_count=%h, required 0", stall_count);
      end
      $display("txn stall counter wrap done");
   endtask
`endif

   initial begin
      #20000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;  flush = 1'b0;
      WB_RegWrite = 1'b0;  WB_WriteReg = 5'd0;  WB_rfWriteData = 32'h0;
      drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RS_ALU, 5'd0, 1'b0, 5'd0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_no_stall();
      test_forward();
      test_flush();
      test_back_to_back();
      test_reset_mid();
`ifdef STALL_COUNTER_EN
      test_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
